// File: rtl/burst_ram_pkg.sv
// Shared constants for the burst RAM responder: FSM encodings, command codes
// and beat/mask geometry of the 64-bit burst interface.
package burst_ram_pkg;

  localparam int BeatWidth = 64;
  localparam int MaskWidth = 8;
  localparam int ByteWidth = BeatWidth / MaskWidth;

  localparam logic CmdRead  = 1'b0;
  localparam logic CmdWrite = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t StInit       = 3'd0;
  localparam state_t StIdle       = 3'd1;
  localparam state_t StWriteBeats = 3'd2;
  localparam state_t StReadWait   = 3'd3;
  localparam state_t StReadBeats  = 3'd4;

  // Right-shift that turns an address in the configured unit into a 64-bit word index.
  function automatic int word_shift(input int addressing_mode);
    return 3 - addressing_mode;
  endfunction

endpackage

// File: rtl/burst_ram_responder_storage.sv
// Single-port 64-bit storage with per-byte write enables and a registered read.
// Each byte lane is its own array so every lane maps onto a plain block RAM.
module burst_ram_storage
  import burst_ram_pkg::*;
#(
  parameter int DepthBitWidth = 12
) (
  input  logic                     clk,
  input  logic [DepthBitWidth-1:0] addr_i,
  input  logic [MaskWidth-1:0]     we_i,
  input  logic [BeatWidth-1:0]     wdata_i,
  input  logic                     re_i,
  output logic [BeatWidth-1:0]     rdata_o
);

  localparam int Depth = 2 ** DepthBitWidth;

  for (genvar gi = 0; gi < MaskWidth; gi++) begin : g_lane
    logic [ByteWidth-1:0] lane_mem [Depth];
    logic [ByteWidth-1:0] lane_q;

    always_ff @(posedge clk) begin
      if (we_i[gi]) begin
        lane_mem[addr_i] <= wdata_i[gi*ByteWidth +: ByteWidth];
      end
      if (re_i) begin
        lane_q <= lane_mem[addr_i];
      end
    end

    assign rdata_o[gi*ByteWidth +: ByteWidth] = lane_q;
  end

endmodule

// File: rtl/burst_ram_responder.sv
// Responder side of the PSRAM HS burst interface backed by on-chip storage.
// Checks calibration and command-interval rules and flags rejected commands.
module burst_ram_responder
  import burst_ram_pkg::*;
#(
  parameter int AddressBitWidth       = 21,
  parameter int AddressingMode        = 0,
  parameter int StorageDepthBitWidth  = 12,
  parameter int BurstBeats            = 4,
  parameter int ReadLatencyCycles     = 8,
  parameter int CommandIntervalCycles = 14,
  parameter int InitCycles            = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_i,
  input  logic                       cmd_en_i,
  input  logic [AddressBitWidth-1:0] addr_i,
  input  logic [BeatWidth-1:0]       wr_data_i,
  input  logic [MaskWidth-1:0]       data_mask_i,
  output logic [BeatWidth-1:0]       rd_data_o,
  output logic                       rd_data_valid_o,
  output logic                       init_calib_o,
  output logic                       busy_o,
  output logic                       cmd_error_o
);

  localparam int  Shift      = word_shift(AddressingMode);
  localparam int  Sdw        = StorageDepthBitWidth;
  localparam int  PhW        = $clog2(ReadLatencyCycles + BurstBeats + 1);
  localparam int  BeatW      = $clog2(BurstBeats + 1);
  localparam int  IvlW       = $clog2(CommandIntervalCycles + 1);
  localparam int  InitW      = $clog2(InitCycles + 1);
  localparam bit  EarlyIssue = (ReadLatencyCycles == 2);

  if (ReadLatencyCycles < 2) begin : g_err_latency
    $error("burst_ram_responder: ReadLatencyCycles must be at least 2");
  end
  if (ReadLatencyCycles + BurstBeats > CommandIntervalCycles) begin : g_err_interval
    $error("burst_ram_responder: ReadLatencyCycles + BurstBeats exceeds CommandIntervalCycles");
  end
  if (AddressingMode < 0 || AddressingMode > 3) begin : g_err_mode
    $error("burst_ram_responder: AddressingMode must be 0..3");
  end
  if (InitCycles < 1 || BurstBeats < 1) begin : g_err_counts
    $error("burst_ram_responder: InitCycles and BurstBeats must be at least 1");
  end

  state_t             state_q;
  logic [InitW-1:0]   init_cnt_q;
  logic               init_calib_q;
  logic [IvlW-1:0]    ivl_q;
  logic [PhW-1:0]     phase_q;
  logic [BeatW-1:0]   beat_q;
  logic [Sdw-1:0]     ptr_q;
  logic               cmd_error_q;
  logic               rd_pend_q;
  logic               rd_valid_q;
  logic [BeatWidth-1:0] rd_data_q;

  logic [Sdw-1:0]       base;
  logic                 accept;
  logic                 accept_wr;
  logic                 accept_rd;
  logic                 read_active;
  logic                 issue_from_state;
  logic                 wr_active;
  logic                 mem_re;
  logic [MaskWidth-1:0] mem_we;
  logic [Sdw-1:0]       mem_addr;
  logic [BeatWidth-1:0] mem_rdata;

  // Zero-extend before shifting so narrow address buses still yield a full-width index.
  assign base = Sdw'({{Sdw{1'b0}}, addr_i} >> Shift);

  assign accept    = cmd_en_i && (state_q == StIdle) && (ivl_q == '0);
  assign accept_wr = accept && (cmd_i == CmdWrite);
  assign accept_rd = accept && (cmd_i == CmdRead);

  // Reads are issued two cycles ahead of the beat: one for the RAM, one for rd_data_q.
  assign read_active      = (state_q == StReadWait) || (state_q == StReadBeats);
  assign issue_from_state = read_active
                         && (phase_q >= PhW'(ReadLatencyCycles - 2))
                         && (beat_q < BeatW'(BurstBeats));
  assign mem_re   = issue_from_state || (accept_rd && EarlyIssue);

  assign wr_active = rst_n && (accept_wr || (state_q == StWriteBeats));
  assign mem_we    = wr_active ? ~data_mask_i : '0;
  assign mem_addr  = accept ? base : ptr_q;

  burst_ram_storage #(
    .DepthBitWidth(Sdw)
  ) u_storage (
    .clk     (clk),
    .addr_i  (mem_addr),
    .we_i    (mem_we),
    .wdata_i (wr_data_i),
    .re_i    (mem_re),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StInit;
      init_cnt_q   <= '0;
      init_calib_q <= 1'b0;
      ivl_q        <= '0;
      phase_q      <= '0;
      beat_q       <= '0;
      ptr_q        <= '0;
      cmd_error_q  <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      rd_pend_q  <= mem_re;
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        rd_data_q <= mem_rdata;
      end

      if (accept) begin
        ivl_q <= IvlW'(CommandIntervalCycles - 1);
      end else if (ivl_q != '0) begin
        ivl_q <= ivl_q - 1'b1;
      end

      if (cmd_en_i && !accept) begin
        cmd_error_q <= 1'b1;
      end

      case (state_q)
        StInit: begin
          if (init_cnt_q == InitW'(InitCycles - 1)) begin
            init_calib_q <= 1'b1;
            state_q      <= StIdle;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end

        StIdle: begin
          if (accept_wr && (BurstBeats > 1)) begin
            state_q <= StWriteBeats;
            ptr_q   <= base + Sdw'(1);
            beat_q  <= BeatW'(1);
          end else if (accept_rd) begin
            state_q <= StReadWait;
            phase_q <= PhW'(1);
            ptr_q   <= EarlyIssue ? base + Sdw'(1) : base;
            beat_q  <= EarlyIssue ? BeatW'(1) : BeatW'(0);
          end
        end

        StWriteBeats: begin
          ptr_q  <= ptr_q + Sdw'(1);
          beat_q <= beat_q + 1'b1;
          if (beat_q == BeatW'(BurstBeats - 1)) begin
            state_q <= StIdle;
          end
        end

        StReadWait, StReadBeats: begin
          phase_q <= phase_q + 1'b1;
          if (issue_from_state) begin
            ptr_q  <= ptr_q + Sdw'(1);
            beat_q <= beat_q + 1'b1;
          end
          if (state_q == StReadWait && phase_q == PhW'(ReadLatencyCycles - 1)) begin
            state_q <= StReadBeats;
          end
          if (state_q == StReadBeats
              && phase_q == PhW'(ReadLatencyCycles + BurstBeats - 1)) begin
            state_q <= StIdle;
          end
        end

        default: begin
          state_q <= StInit;
        end
      endcase
    end
  end

  assign rd_data_o       = rd_data_q;
  assign rd_data_valid_o = rd_valid_q;
  assign init_calib_o    = init_calib_q;
  assign cmd_error_o     = cmd_error_q;
  assign busy_o          = !init_calib_q || (state_q != StIdle) || (ivl_q != '0);

endmodule

// File: tb/tb_burst_ram_responder.sv
// Directed bench for burst_ram_responder: a default-depth instance and a 16-word
// instance share the same stimulus; the small one exercises storage wrap-around.
module tb_burst_ram_responder;

  localparam int Lat   = 8;
  localparam int Beats = 4;

  logic        clk;
  logic        rst_n;
  logic        cmd;
  logic        cmd_en;
  logic [20:0] addr;
  logic [63:0] wr_data;
  logic [7:0]  data_mask;

  logic [63:0] rd_data_m, rd_data_w;
  logic        rd_valid_m, rd_valid_w;
  logic        init_m, init_w;
  logic        busy_m, busy_w;
  logic        err_m, err_w;

  int n_cmp;
  int n_bad;

  burst_ram_responder u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_i           (cmd),
    .cmd_en_i        (cmd_en),
    .addr_i          (addr),
    .wr_data_i       (wr_data),
    .data_mask_i     (data_mask),
    .rd_data_o       (rd_data_m),
    .rd_data_valid_o (rd_valid_m),
    .init_calib_o    (init_m),
    .busy_o          (busy_m),
    .cmd_error_o     (err_m)
  );

  burst_ram_responder #(
    .StorageDepthBitWidth(4)
  ) u_dut_wrap (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_i           (cmd),
    .cmd_en_i        (cmd_en),
    .addr_i          (addr),
    .wr_data_i       (wr_data),
    .data_mask_i     (data_mask),
    .rd_data_o       (rd_data_w),
    .rd_data_valid_o (rd_valid_w),
    .init_calib_o    (init_w),
    .busy_o          (busy_w),
    .cmd_error_o     (err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_inputs();
    cmd       = 1'b0;
    cmd_en    = 1'b0;
    addr      = '0;
    wr_data   = '0;
    data_mask = '0;
  endtask

  // Hold reset one cycle, release, and wait for calibration to complete.
  task automatic reset_and_init(input string tag);
    rst_n = 1'b0;
    idle_inputs();
    tick();
    check_val({tag, "_rst_err"}, 64'(err_m), 64'd0);
    check_val({tag, "_rst_busy"}, 64'(busy_m), 64'd1);
    rst_n = 1'b1;
    wait_cycles(16);
    check_val({tag, "_calib"}, 64'(init_m), 64'd1);
  endtask

  task automatic write_burst(input string tag, input logic [20:0] a,
                             input logic [63:0] d0, input logic [63:0] d1,
                             input logic [63:0] d2, input logic [63:0] d3,
                             input logic [7:0] m0, input logic [7:0] m1,
                             input logic [7:0] m2, input logic [7:0] m3);
    logic [63:0] d [4];
    logic [7:0]  m [4];
    d = '{d0, d1, d2, d3};
    m = '{m0, m1, m2, m3};
    check_val({tag, "_wr_ready"}, 64'(busy_m), 64'd0);
    cmd    = 1'b1;
    cmd_en = 1'b1;
    addr   = a;
    for (int k = 0; k < Beats; k++) begin
      wr_data   = d[k];
      data_mask = m[k];
      tick();
      cmd_en = 1'b0;
    end
    idle_inputs();
  endtask

  // Issue a read at cycle T and check valid/data every cycle through T+Lat+Beats.
  // intr > 0 pulses a write command at cycle T+intr; nchk limits data checks.
  task automatic read_burst(input string tag, input logic [20:0] a,
                            input logic [63:0] e0, input logic [63:0] e1,
                            input logic [63:0] e2, input logic [63:0] e3,
                            input bit use_wrap, input int nchk, input int intr);
    logic [63:0] e [4];
    logic        v;
    logic [63:0] dat;
    e = '{e0, e1, e2, e3};
    cmd    = 1'b0;
    cmd_en = 1'b1;
    addr   = a;
    for (int p = 1; p <= Lat + Beats; p++) begin
      tick();
      idle_inputs();
      if (p == intr) begin
        cmd     = 1'b1;
        cmd_en  = 1'b1;
        addr    = a;
        wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      v   = use_wrap ? rd_valid_w : rd_valid_m;
      dat = use_wrap ? rd_data_w : rd_data_m;
      check_val($sformatf("%s_valid_p%0d", tag, p), 64'(v),
                64'((p >= Lat && p < Lat + Beats) ? 1 : 0));
      if (p >= Lat && p < Lat + Beats && (p - Lat) < nchk) begin
        check_val($sformatf("%s_beat%0d", tag, p - Lat), dat, e[p - Lat]);
      end
      if (p == Lat + Beats && nchk == Beats) begin
        check_val({tag, "_hold"}, dat, e[Beats-1]);
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    idle_inputs();

    // Reset state
    wait_cycles(3);
    check_val("rst_rd_data", rd_data_m, 64'd0);
    check_val("rst_valid", 64'(rd_valid_m), 64'd0);
    check_val("rst_calib", 64'(init_m), 64'd0);
    check_val("rst_busy", 64'(busy_m), 64'd1);
    check_val("rst_err", 64'(err_m), 64'd0);

    // Calibration with an early command that must be dropped
    rst_n = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 5) begin
        cmd    = 1'b1;
        cmd_en = 1'b1;
        addr   = 21'h40;
      end
      if (c == 6) idle_inputs();
      if (c == 15) check_val("calib_c15", 64'(init_m), 64'd0);
      if (c == 16) begin
        check_val("calib_c16", 64'(init_m), 64'd1);
        check_val("calib_err", 64'(err_m), 64'd1);
        check_val("calib_busy", 64'(busy_m), 64'd0);
      end
    end

    reset_and_init("reinit1");

    // Write then read at the same address, exactly one interval apart
    write_burst("wr40", 21'h40, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}},
                8'h00, 8'h00, 8'h00, 8'h00);
    check_val("wr40_busy_t4", 64'(busy_m), 64'd1);
    wait_cycles(9);
    check_val("wr40_busy_t13", 64'(busy_m), 64'd1);
    tick();
    check_val("wr40_busy_t14", 64'(busy_m), 64'd0);
    read_burst("rd40", 21'h40, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, 1'b0, 4, 0);
    check_val("rd40_err", 64'(err_m), 64'd0);
    wait_cycles(2);

    // Byte mask: upper four bytes of beat 0 kept, other beats fully masked
    write_burst("wr80a", 21'h80, '1, '1, '1, '1, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_cycles(10);
    write_burst("wr80b", 21'h80, '0, '0, '0, '0, 8'hF0, 8'hFF, 8'hFF, 8'hFF);
    wait_cycles(10);
    read_burst("rd80", 21'h80, 64'hFFFF_FFFF_0000_0000, '1, '1, '1, 1'b0, 4, 0);
    check_val("rd80_err", 64'(err_m), 64'd0);
    wait_cycles(2);

    // Interval violation: write pulsed mid-read is dropped
    read_burst("rdviol", 21'h40, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, 1'b0, 4, 10);
    check_val("viol_err", 64'(err_m), 64'd1);
    wait_cycles(2);
    read_burst("rdpost", 21'h40, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, 1'b0, 4, 0);
    wait_cycles(2);

    // Wrap-around on the 16-word instance: words 14, 15, 0, 1
    write_burst("wr70", 21'h70, {16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}},
                8'h00, 8'h00, 8'h00, 8'h00);
    wait_cycles(10);
    read_burst("rdw70", 21'h70, {16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}}, 1'b1, 4, 0);
    wait_cycles(2);
    read_burst("rdw00", 21'h00, {16{4'hC}}, {16{4'hD}}, '0, '0, 1'b1, 2, 0);
    wait_cycles(2);
    read_burst("rdm70", 21'h70, {16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}}, 1'b0, 4, 0);
    wait_cycles(2);

    // Reset during the second valid beat of a read
    cmd    = 1'b0;
    cmd_en = 1'b1;
    addr   = 21'h40;
    tick();
    idle_inputs();
    wait_cycles(Lat);
    check_val("mid_valid_b1", 64'(rd_valid_m), 64'd1);
    check_val("mid_data_b1", rd_data_m, {16{4'h2}});
    rst_n = 1'b0;
    tick();
    check_val("mid_valid_after", 64'(rd_valid_m), 64'd0);
    check_val("mid_busy_after", 64'(busy_m), 64'd1);
    rst_n = 1'b1;
    wait_cycles(16);
    check_val("mid_calib", 64'(init_m), 64'd1);
    read_burst("rdafter", 21'h40, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, 1'b0, 4, 0);
    check_val("rdafter_err", 64'(err_m), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/burst_ram_responder.md
Name: burst_ram_responder

Overview:
- Responder end of the Gowin PSRAM HS burst interface (IPUG943) that the cache drives. Accepts one-cycle read/write commands and exchanges 4-beat x 64-bit bursts from on-chip storage.
- Used as a synthesizable stand-in for the PSRAM IP in simulation and in FPGA builds without PSRAM.
- Also enforces the command-interval and calibration rules, flagging initiator protocol violations.

Parameters:
- AddressBitWidth, 21, width of addr.
- AddressingMode, 0, bytes per address: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B. Word index is addr >> (3 - AddressingMode).
- StorageDepthBitWidth, 12, storage holds 2^value 64-bit words. Word index is truncated to this width, so accesses wrap.
- BurstBeats, 4, 64-bit beats per burst.
- ReadLatencyCycles, 8, cycles from accepted read cmd_en to the first rd_data_valid. Minimum 2.
- CommandIntervalCycles, 14, minimum cycles between accepted commands.
- InitCycles, 16, cycles after reset release before init_calib rises.
- Elaboration error unless ReadLatencyCycles + BurstBeats <= CommandIntervalCycles.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- cmd  in  1  0 = read, 1 = write; sampled with cmd_en
- cmd_en  in  1  command and addr valid; one-cycle pulse
- addr  in  AddressBitWidth  burst start address, unit per AddressingMode
- wr_data  in  64  write beat data
- data_mask  in  8  bit i = 1 masks (does not write) byte i of the current beat
- rd_data  out  64  read beat data
- rd_data_valid  out  1  rd_data holds a read beat
- init_calib  out  1  responder ready to accept commands
- busy  out  1  calibration pending, burst in progress, or interval counter nonzero
- cmd_error  out  1  sticky protocol-violation flag

Behaviour:
- Reset values: rd_data = 0, rd_data_valid = 0, init_calib = 0, cmd_error = 0, busy = 1, state = Init, counters = 0. Storage contents are not cleared.
- Reset mid-burst aborts the burst immediately; rd_data_valid is 0 on the next cycle. Writes already committed stay.
- Init: count InitCycles, then init_calib <= 1 and go to Idle. init_calib stays 1 until reset.
- Command acceptance: accept when cmd_en = 1, state = Idle and interval counter = 0.
  - On accept, load the counter with CommandIntervalCycles - 1; it decrements to 0.
  - A command already accepted is never disturbed.
- Rejected cmd_en (state Init, burst active, or counter nonzero): the command is dropped and cmd_error <= 1. cmd_error clears only on reset.
- Write burst, cmd_en at cycle T:
  - Beat k (k = 0..BurstBeats-1) is sampled at T + k, together with data_mask, and written to word (base + k) mod depth.
  - Beat 0 arrives in the same cycle as cmd_en.
  - States: Idle -> WriteBeats (beats 1..BurstBeats-1) -> Idle.
- Read burst, cmd_en at cycle T:
  - rd_data_valid = 1 for exactly BurstBeats consecutive cycles, T+ReadLatencyCycles through T+ReadLatencyCycles+BurstBeats-1.
  - Beat k carries word (base + k) mod depth.
  - States: Idle -> ReadWait (latency counter) -> ReadBeats -> Idle.
  - Storage has a synchronous read; reads are issued one cycle early so that rd_data is registered.
- Outside valid beats, rd_data holds the last beat value.
- Read-after-write to the same address returns the new data, because the write completes long before the next command can be accepted.
- base = addr >> (3 - AddressingMode), truncated to StorageDepthBitWidth bits. The burst wraps at the end of storage, not at a burst boundary.
- busy = !init_calib || state != Idle || counter != 0. It is combinational from registered state.

Decomposition:
- Package burst_ram_pkg holds:
  - the state enum: Init, Idle, WriteBeats, ReadWait, ReadBeats;
  - command constants CmdRead = 0, CmdWrite = 1;
  - beat width 64 and mask width 8.
- Sub-module burst_ram_storage: 64-bit wide, 2^StorageDepthBitWidth deep, 8 byte write enables, synchronous read, one port.
  - The responder drives the byte write enables with ~data_mask during write beats.

Test Plan:
- Calibration: release reset and pulse cmd_en at cycle 5 -> init_calib rises at cycle 16; the early command is dropped and cmd_error = 1.
- Write then read:
  - Stimulus: after init, write addr 0x000040, beats 0x1111..1111, 0x2222..2222, 0x3333..3333, 0x4444..4444, mask 0. At T+14, read addr 0x000040.
  - Required: rd_data_valid is high from T+14+8 through T+14+11, carrying the four beats in order; cmd_error stays 0.
- Byte mask: write 0xFFFF_FFFF_FFFF_FFFF to all beats at addr 0x80, then rewrite beat 0 with 0x0 and data_mask 8'hF0 -> readback beat 0 = 0xFFFF_FFFF_0000_0000, beats 1-3 unchanged.
- Interval violation: accept a read at T, pulse a write at T+10 -> the write is ignored, cmd_error = 1, the read burst completes intact and memory is unchanged.
- Wrap-around with StorageDepthBitWidth = 4 and AddressingMode = 0: write 4 beats at addr 0x70 (word 14) -> words 14, 15, 0, 1 are written; a read at addr 0x00 returns beats 2 and 3 in its first two beats.
- Reset mid-read: assert rst_n = 0 during the second valid beat -> rd_data_valid = 0 next cycle and busy = 1; after re-init, the earlier written data reads back unchanged.
